c17_array_bist: RTL and testbench
=================================

Name: c17_array_bist

Overview:
- Parametrised, pipelined successor to the flat c17 NAND2X1 netlist: LANES independent copies of the c17 function behind a registered pipeline.
- Functional mode uses a valid/ready handshake.
- Built-in self-test exhaustively applies all 32 input patterns to every lane, checks them against a golden table, counts mismatches and compacts lane 0 into a MISR signature.
- Sits between extracted-netlist regression benches and the gate-extraction flow as the sign-off check for c17-class arrays.

Parameters:
- LANES, 4, number of c17 copies (1..16)
- PIPE_STAGES, 1, extra register stages after the input register (0..3); latency LAT = 1 + PIPE_STAGES

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  functional input valid
- in_ready  out  1  high when not in BIST (states IDLE only)
- in_data  in  5*LANES  per lane {I1,I2,I3,I6,I7}, lane k at [5k+4:5k], I1 = MSB
- out_valid  out  1  functional result valid
- out_data  out  2*LANES  per lane {O22,O23} at [2k+1:2k]
- start  in  1  BIST request (level sampled in IDLE)
- busy  out  1  high in WAIT/RUN/DRAIN
- done  out  1  one-cycle pulse at end of BIST
- pass  out  1  err_count == 0 after last BIST
- err_count  out  $clog2(32*LANES+1)  total mismatches, saturating
- lane_fail  out  LANES  sticky per-lane mismatch flag
- signature  out  16  MISR state

Behaviour:
- Logic per lane: net10=~(I1&I3), net11=~(I3&I6), net16=~(I2&net11), net19=~(net11&I7), O22=~(net10&net16), O23=~(net16&net19).
- Reset: all outputs 0 except in_ready=1; all pipeline valids 0; signature = 16'hFFFF; FSM to IDLE.
- Functional mode: a beat is accepted when in_valid & in_ready. out_valid/out_data follow exactly LAT cycles later. No backpressure on output. Data in flight always drains.
- FSM states:
  - IDLE→WAIT on start.
  - WAIT→RUN when all pipeline valids are 0 (immediate if already empty). On entering RUN: clear err_count, lane_fail; signature = 16'hFFFF.
  - RUN: 32 cycles, pattern counter p = 0..31 driven to every lane with valid tag; counter wraps to 0 on exit.
  - RUN→DRAIN after p=31.
  - DRAIN: LAT cycles.
  - DRAIN→DONE; DONE→IDLE after one cycle (done=1 during DONE only).
- Pattern mapping: p[4]=I1, p[3]=I2, p[2]=I3, p[1]=I6, p[0]=I7.
- Checking: each BIST beat carries its p through the pipeline. At the output, lane k's {O22,O23} is compared to C17_GOLDEN[p]. Any mismatch: err_count += number of mismatching lanes that cycle (saturating at max), and lane_fail[k] is set.
- MISR: 16-bit, polynomial x^16+x^12+x^3+x+1. Shifts once per BIST output beat, XORing lane 0 {O22,O23} into bits [1:0].
- out_valid is suppressed for BIST beats.
- Results (pass, err_count, lane_fail, signature) hold until the next RUN entry.
- start while busy or in DONE: ignored.
- in_valid while in_ready=0: ignored; the beat is dropped.
- rst mid-BIST: abort, all reset values, results cleared.

Optional Feature:
- Macro: C17_FAULT_INJ_EN.
- Defined: adds ports fault_en (in 1) and fault_lane (in $clog2(LANES)). While fault_en=1, O22 of lane fault_lane is inverted at the final pipeline stage, in both functional and BIST modes.
- Undefined: ports absent, no inversion logic.

Decomposition:
- Package c17_pkg:
  - C17_GOLDEN (32x2 constant table)
  - MISR_POLY (16'h100B)
  - MISR_SEED (16'hFFFF)
  - bist_state_t enum {IDLE, WAIT, RUN, DRAIN, DONE}
  - lane-field width constants (IN_W=5, OUT_W=2)
- Sub-module c17_lane: combinational c17 function, instantiated LANES times via generate.

Test Plan:
- Functional, LANES=4, PIPE_STAGES=1:
  - lane0 in=5'b00000 → out_data[1:0]=2'b00, out_valid exactly 2 cycles later.
  - lane0 in=5'b11111 → 2'b10.
  - lane0 in=5'b00101 → 2'b01.
- BIST clean run: pulse start in IDLE:
  - busy=1 for 1+32+2 cycles.
  - done pulses once.
  - pass=1, err_count=0, lane_fail=0.
  - signature equals the reference-model MISR over C17_GOLDEN[0..31].
- Fault injection (C17_FAULT_INJ_EN), fault_en=1, fault_lane=2 during BIST:
  - err_count=32, lane_fail=4'b0100, pass=0.
  - signature unchanged vs clean run.
- start asserted with 2 functional beats in flight:
  - FSM holds WAIT until both beats emerge with out_valid.
  - in_ready=0 from the start-sample cycle.
- Assert rst at RUN p=10:
  - next cycle: busy=0, err_count=0, signature=16'hFFFF, in_ready=1.
  - a new start completes a full clean pass.
- Sweep PIPE_STAGES 0..3 and LANES 1/16:
  - functional latency = 1+PIPE_STAGES.
  - BIST pass=1 and signature identical across all configs.

Source files
------------

// File: rtl/c17_pkg.sv
// Shared types, constants and helpers for the c17 lane array with built-in self-test.
package c17_pkg;

  localparam int IN_W  = 5;
  localparam int OUT_W = 2;
  localparam int NPAT  = 32;

  localparam logic [15:0] MISR_POLY = 16'h100B;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Entry p is {O22,O23} for pattern p = {I1,I2,I3,I6,I7}; leftmost entry is p=31.
  localparam logic [NPAT-1:0][OUT_W-1:0] C17_GOLDEN = {
    2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
    2'b10, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00,
    2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
    2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00
  };

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RUN,
    DRAIN,
    DONE
  } bist_state_t;

  // Galois-form MISR step for x^16+x^12+x^3+x+1, new data folded into the low bits.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [OUT_W-1:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {14'h0000, d};
  endfunction

endpackage

// File: rtl/c17_lane.sv
// One combinational copy of the c17 NAND network: {I1,I2,I3,I6,I7} in, {O22,O23} out.
module c17_lane
  import c17_pkg::*;
(
  input  logic [IN_W-1:0]  in_bits,
  output logic [OUT_W-1:0] out_bits
);

  logic i1, i2, i3, i6, i7;
  logic net10, net11, net16, net19;

  assign {i1, i2, i3, i6, i7} = in_bits;

  assign net10 = ~(i1 & i3);
  assign net11 = ~(i3 & i6);
  assign net16 = ~(i2 & net11);
  assign net19 = ~(net11 & i7);

  assign out_bits = {~(net10 & net16), ~(net16 & net19)};

endmodule

// File: rtl/c17_array_bist.sv
// LANES pipelined c17 copies with valid/ready functional mode and exhaustive 32-pattern BIST.
// Optional macro C17_FAULT_INJ_EN adds fault_en/fault_lane to invert one lane's O22 at the output.
module c17_array_bist
  import c17_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 1,
  localparam int ERR_W      = $clog2(32 * LANES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W*LANES-1:0]  in_data,
  output logic                   out_valid,
  output logic [OUT_W*LANES-1:0] out_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [LANES-1:0]       lane_fail,
  output logic [15:0]            signature
`ifdef C17_FAULT_INJ_EN
  ,
  input  logic                   fault_en,
  input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] fault_lane
`endif
);

  localparam int LAT  = 1 + PIPE_STAGES;
  localparam int MC_W = $clog2(LANES + 1);
  localparam logic [4:0]       DRAIN_LAST = 5'(LAT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  bist_state_t state_reg;
  logic [4:0]  cnt_reg;

  logic accept;
  assign accept = in_valid & in_ready;

  // Input register: functional beats or the BIST pattern broadcast to every lane.
  logic [IN_W*LANES-1:0] s0_data_reg;
  logic                  s0_fv_reg;
  logic                  s0_bv_reg;
  logic [4:0]            s0_p_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_data_reg <= '0;
      s0_fv_reg   <= 1'b0;
      s0_bv_reg   <= 1'b0;
      s0_p_reg    <= '0;
    end else begin
      s0_fv_reg <= accept;
      s0_bv_reg <= (state_reg == RUN);
      s0_p_reg  <= cnt_reg;
      if (state_reg == RUN) begin
        s0_data_reg <= {LANES{cnt_reg}};
      end else if (accept) begin
        s0_data_reg <= in_data;
      end
    end
  end

  logic [OUT_W*LANES-1:0] lane_res;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      c17_lane u_lane (
        .in_bits  (s0_data_reg[IN_W*gi +: IN_W]),
        .out_bits (lane_res[OUT_W*gi +: OUT_W])
      );
    end
  endgenerate

  // Result pipeline; element s of each array is the output of stage s.
  logic [OUT_W*LANES-1:0] res_w [PIPE_STAGES+1];
  logic                   fv_w  [PIPE_STAGES+1];
  logic                   bv_w  [PIPE_STAGES+1];
  logic [4:0]             p_w   [PIPE_STAGES+1];

  assign res_w[0] = lane_res;
  assign fv_w[0]  = s0_fv_reg;
  assign bv_w[0]  = s0_bv_reg;
  assign p_w[0]   = s0_p_reg;

  generate
    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
      logic [OUT_W*LANES-1:0] res_reg;
      logic                   fv_reg;
      logic                   bv_reg;
      logic [4:0]             p_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          res_reg <= '0;
          fv_reg  <= 1'b0;
          bv_reg  <= 1'b0;
          p_reg   <= '0;
        end else begin
          res_reg <= res_w[gi];
          fv_reg  <= fv_w[gi];
          bv_reg  <= bv_w[gi];
          p_reg   <= p_w[gi];
        end
      end

      assign res_w[gi+1] = res_reg;
      assign fv_w[gi+1]  = fv_reg;
      assign bv_w[gi+1]  = bv_reg;
      assign p_w[gi+1]   = p_reg;
    end
  endgenerate

  logic                   pipe_busy;
  logic [OUT_W*LANES-1:0] fin_res;
  logic                   fin_bv;
  logic [4:0]             fin_p;

  always_comb begin
    pipe_busy = 1'b0;
    for (int s = 0; s <= PIPE_STAGES; s++) begin
      pipe_busy = pipe_busy | fv_w[s] | bv_w[s];
    end
  end

  assign fin_bv = bv_w[PIPE_STAGES];
  assign fin_p  = p_w[PIPE_STAGES];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_final
`ifdef C17_FAULT_INJ_EN
      logic flip;
      assign flip = fault_en && (int'(fault_lane) == gi);
      assign fin_res[OUT_W*gi +: OUT_W] = res_w[PIPE_STAGES][OUT_W*gi +: OUT_W] ^ {flip, 1'b0};
`else
      assign fin_res[OUT_W*gi +: OUT_W] = res_w[PIPE_STAGES][OUT_W*gi +: OUT_W];
`endif
    end
  endgenerate

  assign out_valid = fv_w[PIPE_STAGES];
  assign out_data  = fin_res;

  // Per-lane compare against the golden table for the pattern tag carried with the beat.
  logic [LANES-1:0] mis;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_check
      assign mis[gi] = fin_bv && (fin_res[OUT_W*gi +: OUT_W] != C17_GOLDEN[fin_p]);
    end
  endgenerate

  logic [MC_W-1:0]  mis_cnt;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_next;

  always_comb begin
    mis_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      mis_cnt = mis_cnt + MC_W'(mis[k]);
    end
    err_sum  = {1'b0, err_count} + (ERR_W + 1)'(mis_cnt);
    err_next = (err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      lane_fail <= '0;
      signature <= MISR_SEED;
    end else begin
      done <= 1'b0;
      if (fin_bv) begin
        err_count <= err_next;
        lane_fail <= lane_fail | mis;
        signature <= misr_step(signature, fin_res[OUT_W-1:0]);
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= WAIT;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          // Functional data already accepted must leave before patterns enter.
          if (!pipe_busy) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            pass      <= 1'b0;
            err_count <= '0;
            lane_fail <= '0;
            signature <= MISR_SEED;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_reg == DRAIN_LAST) begin
            state_reg <= DONE;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_next == '0);
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c17_array_bist.sv
// Scoreboard bench for c17_array_bist: random functional beats plus BIST runs against a reference model.
module tb_c17_array_bist;

  parameter int LANES       = 4;
  parameter int PIPE_STAGES = 1;
  localparam int LAT   = 1 + PIPE_STAGES;
  localparam int ERR_W = $clog2(32 * LANES + 1);
  localparam int FL_W  = (LANES > 1) ? $clog2(LANES) : 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [5*LANES-1:0]   in_data = '0;
  logic                 out_valid;
  logic [2*LANES-1:0]   out_data;
  logic                 start = 1'b0;
  logic                 busy, done, pass;
  logic [ERR_W-1:0]     err_count;
  logic [LANES-1:0]     lane_fail;
  logic [15:0]          signature;
`ifdef C17_FAULT_INJ_EN
  logic                 fault_en = 1'b0;
  logic [FL_W-1:0]      fault_lane = '0;
`endif

  c17_array_bist #(.LANES(LANES), .PIPE_STAGES(PIPE_STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .lane_fail (lane_fail),
    .signature (signature)
`ifdef C17_FAULT_INJ_EN
    ,
    .fault_en  (fault_en),
    .fault_lane(fault_lane)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*LANES-1:0] data;
    int                 due;
  } fexp_t;

  typedef struct {
    logic               pass;
    logic [ERR_W-1:0]   err;
    logic [LANES-1:0]   lf;
    logic [15:0]        sig;
  } bexp_t;

  fexp_t fq[$];
  bexp_t bq[$];
  fexp_t mon_f;
  bexp_t mon_b;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference c17 in sum-of-products form: O22 = I1.I3 + I2.!(I3.I6), O23 = !(I3.I6).(I2 + I7).
  function automatic logic [1:0] c17_ref(input logic [4:0] x);
    logic i1, i2, i3, i6, i7;
    {i1, i2, i3, i6, i7} = x;
    return {(i1 & i3) | (i2 & ~(i3 & i6)), ~(i3 & i6) & (i2 | i7)};
  endfunction

  function automatic logic [15:0] misr_ref();
    logic [15:0] s;
    logic        fb;
    s = 16'hFFFF;
    for (int p = 0; p < 32; p++) begin
      fb = s[15];
      s  = (s << 1) ^ (fb ? 16'h100B : 16'h0000) ^ {14'h0000, c17_ref(5'(p))};
    end
    return s;
  endfunction

  function automatic logic [5*LANES-1:0] rand_data();
    logic [5*LANES-1:0] d;
    for (int k = 0; k < LANES; k++) d[5*k +: 5] = 5'($urandom);
    return d;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a beat or a BIST completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got out_data=%0h expected no beat (cycle %0d)", out_data, cyc);
        end else begin
          mon_f = fq.pop_front();
          check("out_data", out_data, mon_f.data);
          check("out_latency_cycle", cyc, mon_f.due);
          $display("beat: cycle=%0d out_data=%0h expected=%0h", cyc, out_data, mon_f.data);
        end
      end
      if (done) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no BIST completion (cycle %0d)", cyc);
        end else begin
          mon_b = bq.pop_front();
          check("bist_pass", pass, mon_b.pass);
          check("bist_err_count", err_count, mon_b.err);
          check("bist_lane_fail", lane_fail, mon_b.lf);
          check("bist_signature", signature, mon_b.sig);
          $display("bist: cycle=%0d pass=%0d err_count=%0d lane_fail=%0h signature=%04h",
                   cyc, pass, err_count, lane_fail, signature);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [5*LANES-1:0] d);
    fexp_t e;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < LANES; k++) e.data[2*k +: 2] = c17_ref(d[5*k +: 5]);
    e.due = cyc + LAT;
    fq.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_fq_empty();
    for (int n = 0; n < 20 && fq.size() > 0; n++) tick();
    check("functional_drain", fq.size(), 0);
  endtask

  // Runs one BIST; with noise, throws dropped beats and ignored starts at the DUT while busy.
  task automatic run_bist(input bexp_t exp, input int exp_busy, input bit noise, input bit started);
    int busy_cnt = 0;
    int done_cnt = 0;
    bq.push_back(exp);
    if (!started) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int n = 0; n < exp_busy + 10; n++) begin
      @(negedge clk);
      if (n == 0) check("in_ready_low_after_start", in_ready, 1'b0);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      if (noise) begin
        in_valid = busy ? 1'($urandom) : 1'b0;
        in_data  = rand_data();
        start    = done || (busy && (n == 5));
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    tick();
    check("busy_cycles", busy_cnt, exp_busy);
    check("done_pulses", done_cnt, 1);
    check("bist_result_consumed", bq.size(), 0);
    $display("bist run: busy_cycles=%0d done_pulses=%0d", busy_cnt, done_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bexp_t clean;
    logic [5*LANES-1:0] d;
    clean.pass = 1'b1;
    clean.err  = '0;
    clean.lf   = '0;
    clean.sig  = misr_ref();

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_count", err_count, 0);
    check("rst_lane_fail", lane_fail, 0);
    check("rst_signature", signature, 16'hFFFF);
    tick();

    // Directed lane-0 patterns, other lanes random.
    d = rand_data(); d[4:0] = 5'b00000; send_beat(d);
    d = rand_data(); d[4:0] = 5'b11111; send_beat(d);
    d = rand_data(); d[4:0] = 5'b00101; send_beat(d);
    for (int i = 0; i < 40; i++) begin
      if (($urandom % 3) == 0) begin
        in_data = rand_data();
        tick();
      end
      send_beat(rand_data());
    end
    wait_fq_empty();

    run_bist(clean, 1 + 32 + LAT, 1'b1, 1'b0);
    repeat (3) tick();
    check("no_second_bist", busy, 1'b0);

    // Start sampled while two beats are in flight: WAIT holds until the last one leaves.
    send_beat(rand_data());
    start = 1'b1;
    send_beat(rand_data());
    start = 1'b0;
    run_bist(clean, (LAT + 1) + 32 + LAT, 1'b0, 1'b1);
    check("inflight_beats_emerged", fq.size(), 0);

`ifdef C17_FAULT_INJ_EN
    if (LANES > 2) begin
      bexp_t faulty;
      faulty.pass = 1'b0;
      faulty.err  = ERR_W'(32);
      faulty.lf   = LANES'(1) << 2;
      faulty.sig  = clean.sig;
      fault_en   = 1'b1;
      fault_lane = FL_W'(2);
      run_bist(faulty, 1 + 32 + LAT, 1'b0, 1'b0);
      fault_en = 1'b0;
    end
`endif

    // Reset while RUN is applying pattern 10.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_err_count", err_count, 0);
    check("abort_signature", signature, 16'hFFFF);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_lane_fail", lane_fail, 0);
    check("abort_pass", pass, 1'b0);
    tick();

    run_bist(clean, 1 + 32 + LAT, 1'b0, 1'b0);
    send_beat(rand_data());
    wait_fq_empty();
    repeat (4) tick();
    check("scoreboard_empty", fq.size() + bq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
